accumulate_range: RTL
=====================

Name: accumulate_range

Overview:
- Parametrised successor to the single-array sum accumulator.
- Folds a contiguous index range [init_i, init_n) of an internal single-port array into one accumulator, in one of four modes: signed sum, signed min, signed max, or in-place prefix sum.
- The host loads and inspects the array through the controlArr port.
- The block sits behind the host controller as a reusable reduction kernel.

Parameters:
DATA_W, 64, element and accumulator width (signed)
DEPTH, 1000, array entries
ADDR_W, 10, index width; must satisfy 2**ADDR_W >= DEPTH

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
r_enable  in  1  start pulse; samples mode, init_i, init_n, init_acc
mode  in  2  0=sum, 1=min, 2=max, 3=prefix sum with write-back
init_i  in  ADDR_W  first index, inclusive
init_n  in  ADDR_W+1  end index, exclusive
init_acc  in  DATA_W  initial accumulator value
controlArr  in  1  host owns the array port while high
controlArrWEnable  in  1  host write strobe
controlArrAddr  in  ADDR_W  host address
controlArrWData  in  DATA_W  host write data
controlArrRData  out  DATA_W  host read data
busy  out  1  high from start until completion
w_enable  out  1  done flag; rises with result and holds high until the next start
result  out  DATA_W  final accumulator value

Behaviour:
- Reset: clock and reset are fixed as: one clock (clk); reset rst_n is asynchronous and active-low.
  - Asserting rst_n forces state=IDLE, busy=0, w_enable=0, result=0, acc=0 and the index to 0.
  - Array contents are not reset.
  - Reset is honoured mid-operation with no write-back completing afterwards.
- Array: DEPTH x DATA_W, one port. Write happens at the edge. Read is synchronous: data appears the cycle after the address, using a registered address.
  - controlArr=1: the host drives the port.
  - controlArrRData equals the array read data when controlArr was high in both the address cycle and the current cycle; otherwise it is 0.
- Start: r_enable at any edge, including while busy, aborts the current run and loads mode, i=init_i, n=min(init_n, DEPTH) and acc=init_acc. It also sets busy=1, w_enable=0 and state=CHECK.
- FSM states: IDLE, CHECK, READ, ACC, WB, DONE.
  - CHECK:
    - controlArr=1 → stay in CHECK.
    - i>=n → DONE.
    - Otherwise → READ.
  - READ: drives address i (engine read).
    - controlArr=1 → CHECK; the element is retried.
    - Otherwise → ACC.
  - ACC: uses the read data d.
    - controlArr=1 → CHECK, with acc and i unchanged.
    - Otherwise:
      - Sum/prefix: acc <= acc+d, wrapping modulo 2^DATA_W.
      - Min: acc <= (d<acc ? d : acc), signed.
      - Max: acc <= (d>acc ? d : acc), signed.
      - Next state: mode 3 → WB; modes 0-2 → i<=i+1 and CHECK.
  - WB: writes mem[i] <= acc.
    - controlArr=1 → hold in WB; no write occurs.
    - Otherwise → i<=i+1 and CHECK.
  - DONE: result <= acc, w_enable <= 1, busy <= 0, then IDLE.
- Latency, with no stalls, k = max(n-i, 0) elements, start at edge E0:
  - Modes 0-2: w_enable rises at edge E0+3k+2.
  - Mode 3: w_enable rises at edge E0+4k+2.
  - Each cycle controlArr is high in CHECK, READ or WB adds one cycle; a drop in READ or ACC adds the element retry.
- Boundaries:
  - Empty range (init_i >= init_n) → result=init_acc at E0+2.
  - init_n > DEPTH is clamped to DEPTH.
  - The index never wraps.
  - w_enable stays high in IDLE until the next r_enable or reset.
  - When controlArr and the engine would both write, the host wins and the engine write is suppressed.

Test Plan:
- Host writes mem[j]=j for j=0..999; start mode=0, i=0, n=1000, acc=5 → result=499505, w_enable at E0+3002, busy low on the same edge.
- mem[0..3] = {7, -3, 12, -9}; mode=1, i=0, n=4, acc=0 → result=-9; mode=2, acc=0 → result=12; mode=2, acc=-100, n=2 → result=7.
- mem[0..3] = {1,2,3,4}; mode=3, i=0, n=4, acc=0 → result=10 at E0+18; host readback mem[0..3] = {1,3,6,10} with controlArrRData one cycle after the address.
- Empty and clamped ranges: i=7, n=7, acc=42 → result=42 at E0+2. i=998, n=1023, mode=0, mem[998]=1, mem[999]=2, acc=0 → result=3, with no access beyond index 999.
- Host contention: during a mode-0 run over {1,1,1,1}, raise controlArr for 5 cycles in ACC of element 1 → result=4 (no double count or skip); mode 3 with controlArr held during WB → no write until release, and final memory is correct.
- rst_n low for 1 cycle mid-run → busy=0, w_enable=0, result=0 immediately (asynchronous). A restart by r_enable while busy → only the new run's result is reported.

Source files
------------

// File: rtl/accumulate_range.sv
// accumulate_range: folds an index range of an internal single-port array into one accumulator (sum/min/max/prefix-sum).
module accumulate_range #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1000,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r_enable,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] init_i,
    input  logic [ADDR_W:0]   init_n,
    input  logic [DATA_W-1:0] init_acc,
    input  logic              controlArr,
    input  logic              controlArrWEnable,
    input  logic [ADDR_W-1:0] controlArrAddr,
    input  logic [DATA_W-1:0] controlArrWData,
    output logic [DATA_W-1:0] controlArrRData,
    output logic              busy,
    output logic              w_enable,
    output logic [DATA_W-1:0] result
);
    localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, CHECK, READ, ACC, WB, DONE} state_t;

    state_t                   state, state_d;
    logic [1:0]               mode_q;
    logic [ADDR_W:0]          i, i_d, n, n_clamp;
    logic signed [DATA_W-1:0] acc, acc_d, d;
    logic [DATA_W-1:0]        mem [DEPTH];
    logic [ADDR_W-1:0]        addr, addr_q;
    logic [DATA_W-1:0]        wdata;
    logic                     we, ctl_q;

    // The host always owns the port while controlArr is high, so an engine write-back is simply masked.
    assign addr            = controlArr ? controlArrAddr : i[ADDR_W-1:0];
    assign we              = controlArr ? controlArrWEnable : state == WB;
    assign wdata           = controlArr ? controlArrWData : acc;
    assign d               = {1'b0, addr_q} < DEPTH_N ? mem[addr_q] : '0;
    assign controlArrRData = controlArr && ctl_q ? d : '0;
    assign n_clamp         = init_n > DEPTH_N ? DEPTH_N : init_n;

    always_ff @(posedge clk)
        if (we && {1'b0, addr} < DEPTH_N) mem[addr] <= wdata;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            addr_q <= '0;
            ctl_q  <= 1'b0;
        end else begin
            addr_q <= addr;
            ctl_q  <= controlArr;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_d;

    always_comb begin
        state_d = state;
        acc_d   = acc;
        i_d     = i;
        case (state)
            CHECK: state_d = controlArr ? CHECK : (i >= n ? DONE : READ);
            READ:  state_d = controlArr ? CHECK : ACC;
            ACC: begin
                state_d = controlArr ? CHECK : (mode_q == 2'd3 ? WB : CHECK);
                if (!controlArr) begin
                    acc_d = mode_q == 2'd1 ? (d < acc ? d : acc) :
                            mode_q == 2'd2 ? (d > acc ? d : acc) : acc + d;
                    i_d   = mode_q == 2'd3 ? i : i + 1'b1;
                end
            end
            WB: begin
                state_d = controlArr ? WB : CHECK;
                i_d     = controlArr ? i : i + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = state;
        endcase
        if (r_enable) state_d = CHECK;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mode_q   <= '0;
            i        <= '0;
            n        <= '0;
            acc      <= '0;
            busy     <= 1'b0;
            w_enable <= 1'b0;
            result   <= '0;
        end else if (r_enable) begin
            mode_q   <= mode;
            i        <= {1'b0, init_i};
            n        <= n_clamp;
            acc      <= init_acc;
            busy     <= 1'b1;
            w_enable <= 1'b0;
        end else begin
            i   <= i_d;
            acc <= acc_d;
            if (state == DONE) begin
                result   <= acc;
                w_enable <= 1'b1;
                busy     <= 1'b0;
            end
        end
endmodule
